// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the memory bus: arbiter FSM states and bus owner codes.
package cpu_bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Owner codes double as one-hot winner vectors: bit 0 = cpu, bit 1 = ldr.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin winner selection with loader lock.
import cpu_bus_pkg::*;

module arb_rr2 (
  input  logic       cpu_req,
  input  logic       ldr_req,
  input  logic [1:0] last_gnt,
  input  logic       lock,
  output logic [1:0] pick
);

  // Lone requester always wins; on contention the lock keeps the bus with the
  // loader, otherwise the port not granted most recently wins.
  always_comb begin
    pick = OWN_NONE;
    if (cpu_req && ldr_req) begin
      if (lock && (last_gnt == OWN_LDR)) pick = OWN_LDR;
      else if (last_gnt == OWN_CPU)      pick = OWN_LDR;
      else                               pick = OWN_CPU;
    end else if (cpu_req) begin
      pick = OWN_CPU;
    end else if (ldr_req) begin
      pick = OWN_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a loader port onto one synchronous RAM.
// Each access takes three cycles: grant (IDLE), RAM access, done.
import cpu_bus_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  input  logic              ldr_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  logic [1:0]        state;
  logic [1:0]        own;
  logic [1:0]        last_gnt;
  logic [1:0]        pick;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              busy;
  logic              in_idle;
  logic              in_done;

  arb_rr2 u_arb (
    .cpu_req  (cpu_req),
    .ldr_req  (ldr_req),
    .last_gnt (last_gnt),
    .lock     (ldr_lock),
    .pick     (pick)
  );

  // Outputs are gated by rst so an aborted access shows no done, no write and
  // no owner already in the first reset cycle, before the state register clears.
  assign in_idle = rst && (state == ST_IDLE);
  assign in_done = rst && (state == ST_DONE);
  assign busy    = rst && (state != ST_IDLE);

  // FSM, request latches, round-robin pointer and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      own         <= OWN_NONE;
      last_gnt    <= OWN_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick != OWN_NONE) begin
            own      <= pick;
            last_gnt <= pick;
            we_q     <= pick[0] ? cpu_we    : ldr_we;
            addr_q   <= pick[0] ? cpu_addr  : ldr_addr;
            wdata_q  <= pick[0] ? cpu_wdata : ldr_wdata;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: state <= ST_DONE;
        ST_DONE: begin
          if (!we_q && own == OWN_CPU) cpu_rdata_q <= mem_rdata;
          if (!we_q && own == OWN_LDR) ldr_rdata_q <= mem_rdata;
          own   <= OWN_NONE;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Grant/done pulses, RAM drive and owner; read data bypasses the register
  // during done so it is valid in the same cycle as the done pulse.
  always_comb begin
    cpu_gnt   = in_idle && pick[0];
    ldr_gnt   = in_idle && pick[1];
    cpu_done  = in_done && (own == OWN_CPU);
    ldr_done  = in_done && (own == OWN_LDR);
    mem_addr  = busy ? addr_q  : '0;
    mem_wdata = busy ? wdata_q : '0;
    mem_we    = rst && (state == ST_ACCESS) && we_q;
    owner     = busy ? own : OWN_NONE;
    cpu_rdata = (cpu_done && !we_q) ? mem_rdata : cpu_rdata_q;
    ldr_rdata = (ldr_done && !we_q) ? mem_rdata : ldr_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural sync RAM.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_done;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_gnt, ldr_done, ldr_lock;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [1:0] owner;

  logic [7:0] ram [256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         we_cnt   = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
    .ldr_lock(ldr_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'hA5;
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done, mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b exp 00000", {cpu_gnt, ldr_gnt, cpu_done, ldr_done, mem_we});
    end
    n_checks++;
    if (owner !== 2'b00 || mem_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_bus: owner %b addr %h exp 00 00", owner, mem_addr);
    end
    n_checks++;
    if (cpu_rdata !== 8'h00 || ldr_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: cpu %h ldr %h exp 00 00", cpu_rdata, ldr_rdata);
    end
    tick();
  endtask

  task automatic test_cpu_read;
    int we0;
    we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
    #1;
    n_checks++;
    if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rd_gnt: cpu %b ldr %b exp 1 0", cpu_gnt, ldr_gnt);
    end
    tick();
    cpu_addr = 8'h55;
    #1;
    n_checks++;
    if (mem_addr !== 8'h10 || owner !== 2'b01 || cpu_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rd_access: addr %h owner %b gnt %b exp 10 01 0", mem_addr, owner, cpu_gnt);
    end
    tick();
    #1;
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'hA5 || mem_addr !== 8'h10) begin
      n_fail++; $display("FAIL rd_done: done %b rdata %h addr %h exp 1 a5 10", cpu_done, cpu_rdata, mem_addr);
    end
    cpu_req = 1'b0;
    tick();
    #1;
    n_checks++;
    if (cpu_done !== 1'b0 || cpu_rdata !== 8'hA5 || owner !== 2'b00) begin
      n_fail++; $display("FAIL rd_hold: done %b rdata %h owner %b exp 0 a5 00", cpu_done, cpu_rdata, owner);
    end
    n_checks++;
    if (we_cnt - we0 !== 0) begin
      n_fail++; $display("FAIL rd_no_write: we cycles %0d exp 0", we_cnt - we0);
    end
  endtask

  task automatic test_ldr_write_cpu_read;
    int we0;
    we0 = we_cnt;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h3C;
    #1;
    n_checks++;
    if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_fail++; $display("FAIL wr_gnt: ldr %b cpu %b exp 1 0", ldr_gnt, cpu_gnt);
    end
    tick();
    ldr_wdata = 8'hFF; ldr_addr = 8'h21;
    #1;
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 8'h3C || mem_addr !== 8'h20 || owner !== 2'b10) begin
      n_fail++; $display("FAIL wr_access: we %b data %h addr %h owner %b exp 1 3c 20 10", mem_we, mem_wdata, mem_addr, owner);
    end
    tick();
    #1;
    n_checks++;
    if (ldr_done !== 1'b1 || mem_we !== 1'b0 || ldr_rdata !== 8'h00) begin
      n_fail++; $display("FAIL wr_done: done %b we %b rdata %h exp 1 0 00", ldr_done, mem_we, ldr_rdata);
    end
    ldr_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    tick();
    tick();
    #1;
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'h3C) begin
      n_fail++; $display("FAIL wr_readback: done %b rdata %h exp 1 3c", cpu_done, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (we_cnt - we0 !== 1 || ldr_rdata !== 8'h00 || ram[8'h21] !== 8'h00) begin
      n_fail++; $display("FAIL wr_once: we cycles %0d ldr_rdata %h ram21 %h exp 1 00 00", we_cnt - we0, ldr_rdata, ram[8'h21]);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g, exp_d;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20;
    for (int i = 0; i < 12; i++) begin
      exp_g = (i % 6 == 0) ? 2'b01 : (i % 6 == 3) ? 2'b10 : 2'b00;
      exp_d = (i % 6 == 2) ? 2'b01 : (i % 6 == 5) ? 2'b10 : 2'b00;
      #1;
      n_checks++;
      if ({ldr_gnt, cpu_gnt} !== exp_g || {ldr_done, cpu_done} !== exp_d) begin
        n_fail++; $display("FAIL rr_cycle%0d: gnt %b done %b exp %b %b", i, {ldr_gnt, cpu_gnt}, {ldr_done, cpu_done}, exp_g, exp_d);
      end
      tick();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick();
  endtask

  task automatic test_lock;
    logic [1:0] exp_g;
    do_reset();
    ldr_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20;
    for (int i = 0; i < 18; i++) begin
      if (i == 13) ldr_lock = 1'b0;
      exp_g = (i % 3 != 0) ? 2'b00 : (i == 0 || i == 15) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if ({ldr_gnt, cpu_gnt} !== exp_g) begin
        n_fail++; $display("FAIL lock_cycle%0d: gnt %b exp %b", i, {ldr_gnt, cpu_gnt}, exp_g);
      end
      tick();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
    #1;
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL abort_gnt: got %b exp 1", cpu_gnt);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || owner !== 2'b00 || cpu_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_cycle: we %b owner %b done %b exp 0 00 0", mem_we, owner, cpu_done);
    end
    cpu_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (cpu_done !== 1'b0 || owner !== 2'b00 || ram[8'h30] !== 8'h00 || cpu_rdata !== 8'h00) begin
      n_fail++; $display("FAIL abort_after: done %b owner %b ram30 %h rdata %h exp 0 00 00 00", cpu_done, owner, ram[8'h30], cpu_rdata);
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #1;
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL abort_regrant: got %b exp 1", cpu_gnt);
    end
    tick();
    tick();
    #1;
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL abort_reread: done %b rdata %h exp 1 a5", cpu_done, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_early_drop;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    #1;
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL drop_gnt: got %b exp 1", cpu_gnt);
    end
    tick();
    cpu_req = 1'b0;
    tick();
    #1;
    n_checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'h3C) begin
      n_fail++; $display("FAIL drop_done: done %b rdata %h exp 1 3c", cpu_done, cpu_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_checks++;
      if (cpu_gnt !== 1'b0 || owner !== 2'b00) begin
        n_fail++; $display("FAIL drop_idle%0d: gnt %b owner %b exp 0 00", i, cpu_gnt, owner);
      end
    end
  endtask

  initial begin
    rst = 1'b0; ldr_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    tick();
    test_reset();
    test_cpu_read();
    test_ldr_write_cpu_read();
    test_round_robin();
    test_lock();
    test_abort();
    test_early_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
